pipe_decode_stage: RTL and testbench
====================================

// Module: pipe_decode_stage
// PURPOSE
// Parametrised decode stage between fetch and the ALU stage of the pipelined CPU.
// Latches one instruction word per advance with valid/stall/flush handshake and
// decodes opcode into ALU shift/logic/carry selects, write enables and operand fields.
// Also provides a multi-cycle fetch-suppress window after jumps and back-to-back
// RAW forwarding flags against the previously issued instruction.
// PARAMETERS
// DATA_WIDTH       16  instruction word width; must be >= OPCODE_WIDTH+2*REG_ADDR_WIDTH
// OPCODE_WIDTH      7  opcode field = word[OPCODE_WIDTH-1:0]
// REG_ADDR_WIDTH    3  register field width; rhs = next field up, lhs = field above rhs
// SUPPRESS_CYCLES   2  fetch-suppress window length after a jump (>=1)
// PORTS
// clk               in   1   clock, all state on rising edge
// rst_n             in   1   synchronous reset, active low
// PipeIn            in   DW  instruction word from fetch
// in_valid          in   1   PipeIn holds a real instruction
// stall             in   1   downstream hold; stage keeps contents
// flush             in   1   kill stage contents (branch taken)
// in_ready          out  1   = ~stall
// PipeOut           out  DW  latched instruction word
// out_valid         out  1   latched word is a live instruction
// lhs / rhs         out  RAW decoded register fields (full width, no truncation)
// out_shift         out  2   shifter select
// out_logic         out  3   logic-unit select
// out_carry         out  2   carry-in select
// out_wr_en         out  1   result written to register lhs
// out_flags_we      out  1   ALU flags updated
// fwd_lhs / fwd_rhs out  1   operand equals previous instruction's destination
// out_FetchSuppress out  1   fetch must not advance PC
// BEHAVIOUR
// - Reset (rst_n=0 at edge): latch=0, out_valid=0, prev state cleared, counter=0.
//   Reset outputs: PipeOut=0, lhs=rhs=0, shift=0, logic=4, carry=0, wr_en=0,
//   flags_we=0, fwd_*=0, FetchSuppress=0. Reset beats flush beats stall.
// - Advance: flush=1 -> out_valid<=0 (latch word don't-care). Else stall=0 ->
//   latch<=PipeIn, out_valid<=in_valid. Else (stall=1) hold everything.
// - Latency: one clock PipeIn->PipeOut; decode combinational from latch.
// - Decode (opcode: shift,logic,carry,wr_en,flags_we), only when out_valid=1:
//   96 add 0,4,0,1,1 | 97 sub 0,1,1,1,1 | 3 cmp 0,1,1,0,1 | 98 inc 0,0,1,1,1
//   99 dec 0,6,0,1,1 | 100 shl 1,0,0,1,1 | 101 shr 2,0,0,1,1 | 102 and 3,3,0,1,1
//   103 or 3,5,0,1,1 | 104 xor 3,2,0,1,1 | 105 not 0,1,0,1,1
//   any other opcode, or out_valid=0: 0,4,0,0,0 (NOP). lhs/rhs always follow latch.
// - Previous-issue tracker: on each advance (stall=0, flush=0, rst_n=1) with
//   out_valid=1, prev_dest<=lhs, prev_we<=out_wr_en; advance with out_valid=0
//   sets prev_we<=0. Flush clears prev_we. Stall holds.
// - fwd_lhs = out_valid & prev_we & (lhs==prev_dest); fwd_rhs likewise for rhs.
// - Fetch suppress: capturing a valid word with opcode 2 (jump) loads counter
//   with SUPPRESS_CYCLES; counter decrements by 1 each cycle with stall=0 and
//   holds while stall=1; never wraps below 0. A new jump while counter!=0 reloads.
//   out_FetchSuppress = (out_valid & opcode==2) | (counter!=0).
//   Flush clears counter and out_valid, dropping suppress next cycle.
// - Simultaneous stall+flush: flush wins. Counter width = clog2(SUPPRESS_CYCLES+1).
// TESTING
// 1 Reset: rst_n=0 two cycles with in_valid=1, PipeIn=0x0060 -> all outputs at
//   reset values, out_logic=4, out_valid=0; release -> next edge out_valid=1.
// 2 Decode sweep: feed opcodes 96..105, 3, 0x7F with lhs=5, rhs=2 back-to-back
//   -> table values one cycle later, lhs=5, rhs=2, 0x7F gives NOP controls.
// 3 Stall/flush: add then stall=1 3 cycles with changing PipeIn -> PipeOut held;
//   stall=1 & flush=1 same cycle -> out_valid=0 next cycle, wr_en=0.
// 4 Forwarding: add lhs=3 then sub lhs=1 rhs=3 -> fwd_rhs=1, fwd_lhs=0; insert
//   bubble (in_valid=0) between -> fwd_rhs=0; cmp before sub -> fwd_*=0.
// 5 Suppress: SUPPRESS_CYCLES=2, jump captured at edge N -> FetchSuppress=1
//   cycles N+1..N+2 (plus while jump latched), 0 after; stall mid-window
//   extends it by stall length; flush mid-window -> 0 next cycle.
// 6 Params: DATA_WIDTH=24, REG_ADDR_WIDTH=4 -> lhs=word[14:11], rhs=word[10:7].

Source files
------------

// File: rtl/pipe_decode_stage.sv
// Decode stage between fetch and the ALU stage. Holds one instruction word,
// decodes its opcode into ALU control selects, flags back-to-back register
// dependencies against the previously issued instruction, and holds fetch
// off for a few cycles after a jump.
module pipe_decode_stage #(
  parameter int DATA_WIDTH      = 16,
  parameter int OPCODE_WIDTH    = 7,
  parameter int REG_ADDR_WIDTH  = 3,
  parameter int SUPPRESS_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     PipeIn,
  input  logic                      in_valid,
  input  logic                      stall,
  input  logic                      flush,
  output logic                      in_ready,
  output logic [DATA_WIDTH-1:0]     PipeOut,
  output logic                      out_valid,
  output logic [REG_ADDR_WIDTH-1:0] lhs,
  output logic [REG_ADDR_WIDTH-1:0] rhs,
  output logic [1:0]                out_shift,
  output logic [2:0]                out_logic,
  output logic [1:0]                out_carry,
  output logic                      out_wr_en,
  output logic                      out_flags_we,
  output logic                      fwd_lhs,
  output logic                      fwd_rhs,
  output logic                      out_FetchSuppress
);

  localparam int CNT_W  = $clog2(SUPPRESS_CYCLES + 1);
  localparam int RHS_LO = OPCODE_WIDTH;
  localparam int LHS_LO = OPCODE_WIDTH + REG_ADDR_WIDTH;

  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_CMP = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(96);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(97);
  localparam logic [OPCODE_WIDTH-1:0] OP_INC = OPCODE_WIDTH'(98);
  localparam logic [OPCODE_WIDTH-1:0] OP_DEC = OPCODE_WIDTH'(99);
  localparam logic [OPCODE_WIDTH-1:0] OP_SHL = OPCODE_WIDTH'(100);
  localparam logic [OPCODE_WIDTH-1:0] OP_SHR = OPCODE_WIDTH'(101);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND = OPCODE_WIDTH'(102);
  localparam logic [OPCODE_WIDTH-1:0] OP_OR  = OPCODE_WIDTH'(103);
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR = OPCODE_WIDTH'(104);
  localparam logic [OPCODE_WIDTH-1:0] OP_NOT = OPCODE_WIDTH'(105);

  localparam logic [CNT_W-1:0] SUP_LOAD = CNT_W'(SUPPRESS_CYCLES);

  typedef struct packed {
    logic [1:0] shift;
    logic [2:0] lgc;
    logic [1:0] carry;
    logic       wr_en;
    logic       flags_we;
  } ctrl_t;

  // Logic select 4 passes the adder result through; it is the idle selection.
  localparam ctrl_t CTRL_NOP = '{shift: 2'd0, lgc: 3'd4, carry: 2'd0,
                                 wr_en: 1'b0, flags_we: 1'b0};

  function automatic ctrl_t decode_ctrl(input logic [OPCODE_WIDTH-1:0] op);
    ctrl_t c;
    c = CTRL_NOP;
    case (op)
      OP_ADD: c = '{2'd0, 3'd4, 2'd0, 1'b1, 1'b1};
      OP_SUB: c = '{2'd0, 3'd1, 2'd1, 1'b1, 1'b1};
      OP_CMP: c = '{2'd0, 3'd1, 2'd1, 1'b0, 1'b1};
      OP_INC: c = '{2'd0, 3'd0, 2'd1, 1'b1, 1'b1};
      OP_DEC: c = '{2'd0, 3'd6, 2'd0, 1'b1, 1'b1};
      OP_SHL: c = '{2'd1, 3'd0, 2'd0, 1'b1, 1'b1};
      OP_SHR: c = '{2'd2, 3'd0, 2'd0, 1'b1, 1'b1};
      OP_AND: c = '{2'd3, 3'd3, 2'd0, 1'b1, 1'b1};
      OP_OR:  c = '{2'd3, 3'd5, 2'd0, 1'b1, 1'b1};
      OP_XOR: c = '{2'd3, 3'd2, 2'd0, 1'b1, 1'b1};
      OP_NOT: c = '{2'd0, 3'd1, 2'd0, 1'b1, 1'b1};
      default: c = CTRL_NOP;
    endcase
    return c;
  endfunction

  logic [DATA_WIDTH-1:0]     word_p0;
  logic                      vld_p0;
  logic [REG_ADDR_WIDTH-1:0] prev_dest_p0;
  logic                      prev_we_p0;
  logic [CNT_W-1:0]          sup_cnt_p0;

  logic [OPCODE_WIDTH-1:0]   opcode_p0;
  ctrl_t                     ctrl_p0;
  logic                      advance;
  logic                      jump_in;

  assign advance = !flush && !stall;
  assign jump_in = in_valid && (PipeIn[OPCODE_WIDTH-1:0] == OP_JMP);

  // ---- stage p0: instruction latch ----
  // Capture the fetched word on advance; flush only kills validity.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_p0 <= '0;
      vld_p0  <= 1'b0;
    end else if (flush) begin
      vld_p0  <= 1'b0;
    end else if (!stall) begin
      word_p0 <= PipeIn;
      vld_p0  <= in_valid;
    end
  end

  // Remember the destination of the instruction leaving this stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_dest_p0 <= '0;
      prev_we_p0   <= 1'b0;
    end else if (flush) begin
      prev_we_p0   <= 1'b0;
    end else if (advance) begin
      prev_we_p0   <= ctrl_p0.wr_en;
      if (vld_p0) prev_dest_p0 <= lhs;
    end
  end

  // Post-jump fetch-suppress countdown; reloads on every captured jump.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sup_cnt_p0 <= '0;
    end else if (flush) begin
      sup_cnt_p0 <= '0;
    end else if (!stall) begin
      if (jump_in) sup_cnt_p0 <= SUP_LOAD;
      else if (sup_cnt_p0 != '0) sup_cnt_p0 <= sup_cnt_p0 - CNT_W'(1);
    end
  end

  // Combinational decode from the latched word.
  always_comb begin
    opcode_p0 = word_p0[OPCODE_WIDTH-1:0];
    ctrl_p0   = vld_p0 ? decode_ctrl(opcode_p0) : CTRL_NOP;
  end

  assign in_ready          = ~stall;
  assign PipeOut           = word_p0;
  assign out_valid         = vld_p0;
  assign lhs               = word_p0[LHS_LO +: REG_ADDR_WIDTH];
  assign rhs               = word_p0[RHS_LO +: REG_ADDR_WIDTH];
  assign out_shift         = ctrl_p0.shift;
  assign out_logic         = ctrl_p0.lgc;
  assign out_carry         = ctrl_p0.carry;
  assign out_wr_en         = ctrl_p0.wr_en;
  assign out_flags_we      = ctrl_p0.flags_we;
  assign fwd_lhs           = vld_p0 && prev_we_p0 && (lhs == prev_dest_p0);
  assign fwd_rhs           = vld_p0 && prev_we_p0 && (rhs == prev_dest_p0);
  assign out_FetchSuppress = (vld_p0 && (opcode_p0 == OP_JMP)) || (sup_cnt_p0 != '0);

endmodule

// File: tb/tb_pipe_decode_stage.sv
// Bench for pipe_decode_stage: a table-driven reference model checked every
// cycle, directed scenarios with literal expectations, and a wide-field
// instance for the parameterised field positions.
module tb_pipe_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, stall, flush;
  logic [15:0] pipe_in;
  logic        in_ready, out_valid, out_wr_en, out_flags_we, fwd_lhs, fwd_rhs, out_sup;
  logic [15:0] pipe_out;
  logic [2:0]  lhs, rhs, out_logic;
  logic [1:0]  out_shift, out_carry;

  logic [23:0] w_in, w_pipe_out;
  logic        w_valid, w_stall, w_flush;
  logic        w_in_ready, w_out_valid, w_wr_en, w_flags_we, w_fwd_lhs, w_fwd_rhs, w_sup;
  logic [3:0]  w_lhs, w_rhs;
  logic [2:0]  w_logic;
  logic [1:0]  w_shift, w_carry;

  pipe_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .PipeIn(pipe_in), .in_valid(in_valid),
    .stall(stall), .flush(flush), .in_ready(in_ready), .PipeOut(pipe_out),
    .out_valid(out_valid), .lhs(lhs), .rhs(rhs), .out_shift(out_shift),
    .out_logic(out_logic), .out_carry(out_carry), .out_wr_en(out_wr_en),
    .out_flags_we(out_flags_we), .fwd_lhs(fwd_lhs), .fwd_rhs(fwd_rhs),
    .out_FetchSuppress(out_sup)
  );

  pipe_decode_stage #(.DATA_WIDTH(24), .REG_ADDR_WIDTH(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .PipeIn(w_in), .in_valid(w_valid),
    .stall(w_stall), .flush(w_flush), .in_ready(w_in_ready), .PipeOut(w_pipe_out),
    .out_valid(w_out_valid), .lhs(w_lhs), .rhs(w_rhs), .out_shift(w_shift),
    .out_logic(w_logic), .out_carry(w_carry), .out_wr_en(w_wr_en),
    .out_flags_we(w_flags_we), .fwd_lhs(w_fwd_lhs), .fwd_rhs(w_fwd_rhs),
    .out_FetchSuppress(w_sup)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Opcode table: opcode -> control tuple.
  int t_sh[int], t_lg[int], t_cy[int], t_we[int], t_fw[int];

  function automatic void add_op(int op, int sh, int lg, int cy, int we, int fw);
    t_sh[op] = sh; t_lg[op] = lg; t_cy[op] = cy; t_we[op] = we; t_fw[op] = fw;
  endfunction

  function automatic int e_sh(int op, bit v); return (v && t_sh.exists(op)) ? t_sh[op] : 0; endfunction
  function automatic int e_lg(int op, bit v); return (v && t_lg.exists(op)) ? t_lg[op] : 4; endfunction
  function automatic int e_cy(int op, bit v); return (v && t_cy.exists(op)) ? t_cy[op] : 0; endfunction
  function automatic int e_we(int op, bit v); return (v && t_we.exists(op)) ? t_we[op] : 0; endfunction
  function automatic int e_fw(int op, bit v); return (v && t_fw.exists(op)) ? t_fw[op] : 0; endfunction

  function automatic int opc(logic [15:0] w);     return int'(w) % 128;          endfunction
  function automatic int fld_rhs(logic [15:0] w); return (int'(w) / 128) % 8;    endfunction
  function automatic int fld_lhs(logic [15:0] w); return (int'(w) / 1024) % 8;  endfunction

  function automatic logic [15:0] ins(int op, int l, int r);
    return 16'((l % 8) * 1024 + (r % 8) * 128 + (op % 128));
  endfunction

  initial begin
    add_op(96, 0, 4, 0, 1, 1); add_op(97, 0, 1, 1, 1, 1); add_op(3, 0, 1, 1, 0, 1);
    add_op(98, 0, 0, 1, 1, 1); add_op(99, 0, 6, 0, 1, 1); add_op(100, 1, 0, 0, 1, 1);
    add_op(101, 2, 0, 0, 1, 1); add_op(102, 3, 3, 0, 1, 1); add_op(103, 3, 5, 0, 1, 1);
    add_op(104, 3, 2, 0, 1, 1); add_op(105, 0, 1, 0, 1, 1);
  end

  // Reference model state.
  logic [15:0] m_word;
  bit          m_valid, m_known, m_prev_we, m_init;
  int          m_prev_dest, m_cnt;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_word <= '0; m_valid <= 0; m_known <= 1; m_prev_we <= 0;
      m_prev_dest <= 0; m_cnt <= 0; m_init <= 1;
    end else if (m_init) begin
      if (flush) begin
        m_valid <= 0; m_known <= 0; m_prev_we <= 0; m_cnt <= 0;
      end else if (!stall) begin
        m_word <= pipe_in; m_valid <= in_valid; m_known <= 1;
        if (m_valid) begin
          m_prev_dest <= fld_lhs(m_word);
          m_prev_we   <= (e_we(opc(m_word), 1'b1) != 0);
        end else begin
          m_prev_we   <= 0;
        end
        if (in_valid && opc(pipe_in) == 2) m_cnt <= 2;
        else if (m_cnt > 0) m_cnt <= m_cnt - 1;
      end
    end
  end

  // Per-cycle comparison against the model, half a cycle after the edge.
  always @(negedge clk) begin
    if (m_init) begin
      int op;
      op = opc(m_word);
      check("cyc_valid", out_valid, m_valid);
      if (m_known) begin
        check("cyc_pipeout", pipe_out, m_word);
        check("cyc_lhs", lhs, fld_lhs(m_word));
        check("cyc_rhs", rhs, fld_rhs(m_word));
      end
      check("cyc_shift", out_shift, e_sh(op, m_valid));
      check("cyc_logic", out_logic, e_lg(op, m_valid));
      check("cyc_carry", out_carry, e_cy(op, m_valid));
      check("cyc_wr_en", out_wr_en, e_we(op, m_valid));
      check("cyc_flags_we", out_flags_we, e_fw(op, m_valid));
      check("cyc_fwd_lhs", fwd_lhs, m_valid && m_prev_we && (fld_lhs(m_word) == m_prev_dest));
      check("cyc_fwd_rhs", fwd_rhs, m_valid && m_prev_we && (fld_rhs(m_word) == m_prev_dest));
      check("cyc_suppress", out_sup, (m_valid && op == 2) || (m_cnt != 0));
      check("cyc_in_ready", in_ready, !stall);
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  int ops[12] = '{96, 97, 98, 99, 100, 101, 102, 103, 104, 105, 3, 127};
  int pick[15] = '{96, 97, 98, 99, 100, 101, 102, 103, 104, 105, 3, 2, 2, 127, 0};

  initial begin
    rst_n = 0; in_valid = 1; pipe_in = 16'h0060; stall = 0; flush = 0;
    w_in = '0; w_valid = 0; w_stall = 0; w_flush = 0;

    // Reset held two cycles with a live add at the input.
    tick; tick;
    check("rst_valid", out_valid, 0);
    check("rst_logic", out_logic, 4);
    check("rst_pipeout", pipe_out, 0);
    check("rst_wr_en", out_wr_en, 0);
    check("rst_suppress", out_sup, 0);
    rst_n = 1;
    tick;
    check("rel_valid", out_valid, 1);
    check("rel_wr_en", out_wr_en, 1);

    // Decode sweep, back to back, lhs=5 rhs=2.
    for (int i = 0; i < 12; i++) begin
      pipe_in = ins(ops[i], 5, 2);
      tick;
      check("sweep_lhs", lhs, 5);
      check("sweep_rhs", rhs, 2);
      if (ops[i] == 104) begin
        check("sweep_xor_shift", out_shift, 3);
        check("sweep_xor_logic", out_logic, 2);
      end
      if (ops[i] == 97) check("sweep_sub_carry", out_carry, 1);
      if (ops[i] == 3)  check("sweep_cmp_wr_en", out_wr_en, 0);
      if (ops[i] == 127) begin
        check("sweep_nop_logic", out_logic, 4);
        check("sweep_nop_wr_en", out_wr_en, 0);
        check("sweep_nop_flags", out_flags_we, 0);
      end
    end

    // Stall holds contents; stall together with flush kills the stage.
    pipe_in = ins(96, 1, 2);
    tick;
    for (int i = 0; i < 3; i++) begin
      stall = 1; pipe_in = ins(97, i, i + 1);
      tick;
      check("stall_hold", pipe_out, ins(96, 1, 2));
    end
    flush = 1;
    tick;
    check("stallflush_valid", out_valid, 0);
    check("stallflush_wr_en", out_wr_en, 0);
    stall = 0; flush = 0; in_valid = 0;
    tick;
    in_valid = 1;

    // Forwarding: direct, across a bubble, and behind a non-writing cmp.
    pipe_in = ins(96, 3, 0); tick;
    pipe_in = ins(97, 1, 3); tick;
    check("fwd_direct_rhs", fwd_rhs, 1);
    check("fwd_direct_lhs", fwd_lhs, 0);
    pipe_in = ins(96, 3, 0); tick;
    in_valid = 0; tick;
    in_valid = 1; pipe_in = ins(97, 1, 3); tick;
    check("fwd_bubble_rhs", fwd_rhs, 0);
    pipe_in = ins(3, 3, 0); tick;
    pipe_in = ins(97, 1, 3); tick;
    check("fwd_cmp_rhs", fwd_rhs, 0);
    check("fwd_cmp_lhs", fwd_lhs, 0);

    // Fetch suppress: plain window, stall extension, flush cut.
    pipe_in = ins(96, 0, 0); tick;
    pipe_in = ins(2, 0, 0); tick;
    check("sup_jump", out_sup, 1);
    pipe_in = ins(96, 0, 0); tick;
    check("sup_win1", out_sup, 1);
    tick;
    check("sup_after", out_sup, 0);
    pipe_in = ins(2, 0, 0); tick;
    pipe_in = ins(96, 0, 0); stall = 1; tick; tick;
    check("sup_stalled", out_sup, 1);
    stall = 0; tick;
    check("sup_extended", out_sup, 1);
    tick;
    check("sup_ext_after", out_sup, 0);
    pipe_in = ins(2, 0, 0); tick;
    flush = 1; pipe_in = ins(96, 0, 0); tick;
    check("sup_flush", out_sup, 0);
    check("sup_flush_valid", out_valid, 0);
    flush = 0; tick;

    // Wide instance: lhs=word[14:11]=10, rhs=word[10:7]=6, opcode 97.
    w_in = 24'h105361; w_valid = 1; tick;
    check("wide_lhs", w_lhs, 10);
    check("wide_rhs", w_rhs, 6);
    check("wide_logic", w_logic, 1);
    check("wide_carry", w_carry, 1);
    check("wide_wr_en", w_wr_en, 1);
    check("wide_pipeout", w_pipe_out, 24'h105361);
    check("wide_suppress", w_sup, 0);
    w_valid = 0;

    // Mixed traffic checked by the per-cycle model.
    for (int i = 0; i < 300; i++) begin
      pipe_in  = ins(pick[$urandom_range(0, 14)], $urandom_range(0, 3), $urandom_range(0, 3));
      in_valid = ($urandom_range(0, 4) != 0);
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      rst_n    = ($urandom_range(0, 59) != 0);
      tick;
    end
    rst_n = 1; stall = 0; flush = 0; in_valid = 0;
    tick; tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
